oflow_score_calc_engine: RTL and testbench
==========================================

# oflow_score_calc_engine

Responder side of the registration score-calculation handshake. On each `start_score_calc` pulse from the registration FSM it latches one set of `PE_NUM` current-frame centroids and streams `num_of_prev` previous-frame centroids from the previous-frame buffer. Every lane computes a Manhattan-distance score against each candidate and keeps the minimum and its index. Results go to the score board one lane per cycle, then the block pulses `done_score_calc`.

## Interface
- `PE_NUM`, 8: objects per set (lanes); power of two.
- `COORD_W`, 11: width of x and y coordinates (unsigned).
- `SET_LEN`, 4: set-index width.
- `MAX_PREV`, 32: maximum previous-frame objects.
- `CAND_W`, `$clog2(MAX_PREV+1)`: candidate count/index width.
- `SCORE_W`, `COORD_W+1`: score width.
- `clk` in 1: clock.
- `reset_N` in 1: reset, asynchronous, active-low.
- `start_score_calc` in 1: one-cycle start request.
- `set_index` in SET_LEN: set number (`counter_of_sets`), latched on accepted start.
- `num_of_prev` in CAND_W: candidate count, latched on accepted start; 0..MAX_PREV.
- `cur_set` in PE_NUM*2*COORD_W: lane i = {y,x} at bits [2*COORD_W*(i+1)-1 -: 2*COORD_W], latched on accepted start.
- `score_th` in SCORE_W: match threshold, sampled during WRITE.
- `prev_rd_en` out 1: previous-buffer read strobe.
- `prev_rd_addr` out CAND_W-1: candidate index.
- `prev_rd_data` in 2*COORD_W: {y,x}, valid exactly 1 cycle after `prev_rd_en`.
- `sb_wr_en` out 1: score-board write strobe.
- `sb_wr_addr` out SET_LEN+log2(PE_NUM): {set_index, lane}.
- `sb_best_score` out SCORE_W: minimum score for the lane.
- `sb_best_id` out CAND_W-1: candidate index of the minimum.
- `sb_match` out 1: `num_of_prev!=0` && best_score <= score_th.
- `done_score_calc` out 1: one-cycle completion pulse.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE: `start_score_calc` latches the inputs and resets every lane to best_score = all-ones and best_id = 0.
  - If `num_of_prev` != 0, go to READ. Otherwise go to WRITE.
- READ: `prev_rd_en`=1 and `prev_rd_addr`=rd_cnt. rd_cnt runs 0..N-1, then the state moves to DRAIN.
- Compare: in the cycle after each read, every lane computes score = |x_c − x_p| + |y_c − y_p| (zero-extended, SCORE_W bits, cannot overflow).
  - It updates best when score < best (strict), so a tie keeps the lower index.
  - The compare index is the read address delayed by one cycle.
- DRAIN: one cycle that consumes the last read datum, then the state moves to WRITE.
- WRITE: one lane per cycle, lanes 0..PE_NUM-1, with `sb_wr_en`=1. After the last lane the state moves to DONE.
- DONE: `done_score_calc`=1.
  - If `start_score_calc` is high in this cycle, latch, re-initialise the lanes and go to READ/WRITE as from IDLE. The registration FSM issues its next start combinationally in the same cycle as done, so this start must not be lost.
  - Otherwise go to IDLE.
- `start_score_calc` in READ/DRAIN/WRITE is ignored. No error flag.
- `num_of_prev` > MAX_PREV: the count is clamped to MAX_PREV.
- `num_of_prev`=0: all lanes write best_score = all-ones, best_id = 0, `sb_match`=0.

## Timing
- Reset value of every output: 0. State: IDLE. Lane registers: best_score all-ones, best_id 0.
- Reset is asynchronous; asserting it mid-operation aborts immediately, with no done and no further writes.
- With start sampled at edge 0 and N = `num_of_prev`:
  - READ runs in cycles 1..N, DRAIN in N+1.
  - WRITE runs in cycles N+2..N+1+PE_NUM.
  - Done is in cycle N+2+PE_NUM.
- With N=0: WRITE in cycles 1..PE_NUM, done in PE_NUM+1.
- Back-to-back sets: a start in the DONE cycle gives a first READ in the next cycle, with zero idle cycles.
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.

## Structure
- Package `oflow_score_calc_pkg`: state enum `sc_state_t`, default parameter constants, and a `coord_pair_t` struct {y,x}.
- Sub-module `oflow_score_calc_lane`, instantiated PE_NUM times: abs-diff, sum, compare and best registers, with `init`/`upd_en`/`cand_idx` inputs.
- Top level holds the FSM, the rd/compare/write counters, input latches and the write mux.

## Test plan
- Basic set (PE_NUM=4, N=3), with lane0=(10,10) and candidates (0,0),(12,9),(40,40): lane0 writes score 3, id 1, match with th=5. Done arrives 3+4+2=9 cycles after start.
- Tie: lane at (5,5), candidates (4,5),(6,5): score 1, id 0. Repeat with three equal candidates: id 0.
- N=0: four writes, each with score 0xFFF (COORD_W=11), id 0, match 0. Done 5 cycles after start.
- Back-to-back: start held in the DONE cycle with set_index 2 then 3. There must be no idle cycle, and `sb_wr_addr` must carry set 3's prefix (3*4+lane = 12..15).
- Extremes: (0,0) against (2047,2047) gives score 4094 with no overflow. `num_of_prev`=40 is clamped to 32 reads (addr 0..31).
- Reset mid-READ at cycle 2: all outputs are 0 immediately, there is no done, and a new start after release behaves like the basic set.

Source files
------------

// File: rtl/oflow_score_calc_pkg.sv
// rtl/oflow_score_calc_pkg.sv - shared types and defaults for the score-calculation engine
package oflow_score_calc_pkg;

    localparam int DEF_PE_NUM   = 8;
    localparam int DEF_COORD_W  = 11;
    localparam int DEF_SET_LEN  = 4;
    localparam int DEF_MAX_PREV = 32;

    typedef enum logic [2:0] {
        SC_IDLE,
        SC_READ,
        SC_DRAIN,
        SC_WRITE,
        SC_DONE
    } sc_state_t;

    typedef struct packed {
        logic [DEF_COORD_W-1:0] y;
        logic [DEF_COORD_W-1:0] x;
    } coord_pair_t;

endpackage

// File: rtl/oflow_score_calc_lane.sv
// rtl/oflow_score_calc_lane.sv - one lane: Manhattan distance and running minimum
module oflow_score_calc_lane #(
    parameter int COORD_W = 11,
    parameter int CAND_W  = 6,
    parameter int SCORE_W = COORD_W + 1
) (
    input  logic                 clk,
    input  logic                 reset_N,
    input  logic                 init,
    input  logic                 upd_en,
    input  logic [CAND_W-2:0]    cand_idx,
    input  logic [2*COORD_W-1:0] cur_xy,
    input  logic [2*COORD_W-1:0] prev_xy,
    output logic [SCORE_W-1:0]   best_score,
    output logic [CAND_W-2:0]    best_id
);

    logic [COORD_W-1:0] xc, yc, xp, yp, dx, dy;
    logic [SCORE_W-1:0] score;

    assign {yc, xc} = cur_xy;
    assign {yp, xp} = prev_xy;
    assign dx       = (xc >= xp) ? (xc - xp) : (xp - xc);
    assign dy       = (yc >= yp) ? (yc - yp) : (yp - yc);
    assign score    = SCORE_W'(dx) + SCORE_W'(dy);

    // strict less-than keeps the earliest candidate on ties
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            best_score <= '1;
            best_id    <= '0;
        end else if (init) begin
            best_score <= '1;
            best_id    <= '0;
        end else if (upd_en && (score < best_score)) begin
            best_score <= score;
            best_id    <= cand_idx;
        end
    end

endmodule

// File: rtl/oflow_score_calc_engine.sv
// rtl/oflow_score_calc_engine.sv - streams previous-frame candidates through PE_NUM lanes, writes best matches
module oflow_score_calc_engine
    import oflow_score_calc_pkg::*;
#(
    parameter int PE_NUM   = DEF_PE_NUM,
    parameter int COORD_W  = DEF_COORD_W,
    parameter int SET_LEN  = DEF_SET_LEN,
    parameter int MAX_PREV = DEF_MAX_PREV,
    parameter int CAND_W   = $clog2(MAX_PREV + 1),
    parameter int SCORE_W  = COORD_W + 1
) (
    input  logic                          clk,
    input  logic                          reset_N,
    input  logic                          start_score_calc,
    input  logic [SET_LEN-1:0]            set_index,
    input  logic [CAND_W-1:0]             num_of_prev,
    input  logic [PE_NUM*2*COORD_W-1:0]   cur_set,
    input  logic [SCORE_W-1:0]            score_th,
    output logic                          prev_rd_en,
    output logic [CAND_W-2:0]             prev_rd_addr,
    input  logic [2*COORD_W-1:0]          prev_rd_data,
    output logic                          sb_wr_en,
    output logic [SET_LEN+$clog2(PE_NUM)-1:0] sb_wr_addr,
    output logic [SCORE_W-1:0]            sb_best_score,
    output logic [CAND_W-2:0]             sb_best_id,
    output logic                          sb_match,
    output logic                          done_score_calc,
    output logic                          busy
);

    localparam int LANE_W = $clog2(PE_NUM);

    sc_state_t                   state;
    logic [CAND_W-2:0]           rd_cnt, cand_q;
    logic [LANE_W-1:0]           wr_cnt;
    logic [SET_LEN-1:0]          set_q;
    logic [CAND_W-1:0]           n_q, n_eff;
    logic [PE_NUM*2*COORD_W-1:0] cur_q;
    logic [SCORE_W-1:0]          th_q;
    logic                        rd_vld, start_acc, wr_act;
    logic [SCORE_W-1:0]          lane_score [PE_NUM];
    logic [CAND_W-2:0]           lane_id    [PE_NUM];

    assign n_eff     = (num_of_prev > CAND_W'(MAX_PREV)) ? CAND_W'(MAX_PREV) : num_of_prev;
    // a start in DONE is honoured so the registration FSM can chain sets with no gap
    assign start_acc = start_score_calc && ((state == SC_IDLE) || (state == SC_DONE));

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state  <= SC_IDLE;
            rd_cnt <= '0;
            wr_cnt <= '0;
            set_q  <= '0;
            n_q    <= '0;
            cur_q  <= '0;
            rd_vld <= 1'b0;
            cand_q <= '0;
            th_q   <= '0;
        end else begin
            rd_vld <= (state == SC_READ);
            cand_q <= rd_cnt;
            th_q   <= score_th;
            case (state)
                SC_IDLE, SC_DONE: begin
                    if (start_acc) begin
                        set_q  <= set_index;
                        n_q    <= n_eff;
                        cur_q  <= cur_set;
                        rd_cnt <= '0;
                        wr_cnt <= '0;
                        state  <= (n_eff != '0) ? SC_READ : SC_WRITE;
                    end else begin
                        state  <= SC_IDLE;
                    end
                end
                SC_READ: begin
                    if ({1'b0, rd_cnt} == (n_q - CAND_W'(1))) state <= SC_DRAIN;
                    else                                       rd_cnt <= rd_cnt + 1'b1;
                end
                SC_DRAIN: state <= SC_WRITE;
                SC_WRITE: begin
                    if (wr_cnt == LANE_W'(PE_NUM - 1)) state <= SC_DONE;
                    else                               wr_cnt <= wr_cnt + 1'b1;
                end
                default: state <= SC_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < PE_NUM; i++) begin : g_lane
        oflow_score_calc_lane #(
            .COORD_W (COORD_W),
            .CAND_W  (CAND_W),
            .SCORE_W (SCORE_W)
        ) u_lane (
            .clk        (clk),
            .reset_N    (reset_N),
            .init       (start_acc),
            .upd_en     (rd_vld),
            .cand_idx   (cand_q),
            .cur_xy     (cur_q[2*COORD_W*(i+1)-1 -: 2*COORD_W]),
            .prev_xy    (prev_rd_data),
            .best_score (lane_score[i]),
            .best_id    (lane_id[i])
        );
    end

    assign wr_act          = (state == SC_WRITE);
    assign prev_rd_en      = (state == SC_READ);
    assign prev_rd_addr    = prev_rd_en ? rd_cnt : '0;
    assign sb_wr_en        = wr_act;
    assign sb_wr_addr      = wr_act ? {set_q, wr_cnt} : '0;
    assign sb_best_score   = wr_act ? lane_score[wr_cnt] : '0;
    assign sb_best_id      = wr_act ? lane_id[wr_cnt] : '0;
    assign sb_match        = wr_act && (n_q != '0) && (lane_score[wr_cnt] <= th_q);
    assign done_score_calc = (state == SC_DONE);
    assign busy            = (state != SC_IDLE);

endmodule

// File: tb/tb_oflow_score_calc_engine.sv
// tb/tb_oflow_score_calc_engine.sv - directed self-checking bench for oflow_score_calc_engine
module tb_oflow_score_calc_engine;

    localparam int PE_NUM  = 4;
    localparam int COORD_W = 11;
    localparam int SET_LEN = 4;
    localparam int CAND_W  = 6;
    localparam int SCORE_W = 12;
    localparam int WA_W    = SET_LEN + 2;

    logic                        clk = 1'b0;
    logic                        reset_N;
    logic                        start_score_calc;
    logic [SET_LEN-1:0]          set_index;
    logic [CAND_W-1:0]           num_of_prev;
    logic [PE_NUM*2*COORD_W-1:0] cur_set;
    logic [SCORE_W-1:0]          score_th;
    logic                        prev_rd_en;
    logic [CAND_W-2:0]           prev_rd_addr;
    logic [2*COORD_W-1:0]        prev_rd_data;
    logic                        sb_wr_en;
    logic [WA_W-1:0]             sb_wr_addr;
    logic [SCORE_W-1:0]          sb_best_score;
    logic [CAND_W-2:0]           sb_best_id;
    logic                        sb_match;
    logic                        done_score_calc;
    logic                        busy;

    oflow_score_calc_engine #(.PE_NUM(PE_NUM)) dut (
        .clk              (clk),
        .reset_N          (reset_N),
        .start_score_calc (start_score_calc),
        .set_index        (set_index),
        .num_of_prev      (num_of_prev),
        .cur_set          (cur_set),
        .score_th         (score_th),
        .prev_rd_en       (prev_rd_en),
        .prev_rd_addr     (prev_rd_addr),
        .prev_rd_data     (prev_rd_data),
        .sb_wr_en         (sb_wr_en),
        .sb_wr_addr       (sb_wr_addr),
        .sb_best_score    (sb_best_score),
        .sb_best_id       (sb_best_id),
        .sb_match         (sb_match),
        .done_score_calc  (done_score_calc),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    logic [2*COORD_W-1:0] prev_mem [32];
    always @(posedge clk) if (prev_rd_en) prev_rd_data <= prev_mem[prev_rd_addr];

    int errors = 0;
    int checks = 0;

    int n_wr, n_rd, done_cyc, first_rd, first_wr;
    int wr_addr [64];
    int wr_score[64];
    int wr_id   [64];
    int wr_match[64];
    int rd_addr [64];

    task automatic set_lane(input int i, input int x, input int y);
        cur_set[2*COORD_W*i +: 2*COORD_W] = {11'(y), 11'(x)};
    endtask

    task automatic set_prev(input int i, input int x, input int y);
        prev_mem[i] = {11'(y), 11'(x)};
    endtask

    // caller is #1 after a posedge; leaves the bench #1 into cycle 1
    task automatic pulse_start();
        start_score_calc = 1'b1;
        @(posedge clk); #1;
        start_score_calc = 1'b0;
    endtask

    // records activity from cycle 1 until the done cycle (or the budget runs out)
    task automatic capture(input int limit);
        n_wr = 0; n_rd = 0; done_cyc = -1; first_rd = -1; first_wr = -1;
        for (int c = 1; c <= limit; c++) begin
            if (prev_rd_en) begin
                if (first_rd < 0) first_rd = c;
                rd_addr[n_rd] = int'(prev_rd_addr);
                n_rd++;
            end
            if (sb_wr_en) begin
                if (first_wr < 0) first_wr = c;
                wr_addr[n_wr]  = int'(sb_wr_addr);
                wr_score[n_wr] = int'(sb_best_score);
                wr_id[n_wr]    = int'(sb_best_id);
                wr_match[n_wr] = int'(sb_match);
                n_wr++;
            end
            if (done_score_calc) begin
                done_cyc = c;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic load_basic();
        set_lane(0, 10, 10);
        set_lane(1, 40, 41);
        set_lane(2, 0, 0);
        set_lane(3, 100, 100);
        set_prev(0, 0, 0);
        set_prev(1, 12, 9);
        set_prev(2, 40, 40);
        num_of_prev = 6'd3;
        score_th    = 12'd5;
        set_index   = 4'd1;
    endtask

    task automatic test_reset();
        logic [40:0] outs;
        outs = {prev_rd_en, prev_rd_addr, sb_wr_en, sb_wr_addr, sb_best_score,
                sb_best_id, sb_match, done_score_calc, busy};
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
    endtask

    task automatic test_basic();
        int exp_s[4] = '{3, 1, 0, 120};
        int exp_i[4] = '{1, 2, 0, 2};
        int exp_m[4] = '{1, 1, 1, 0};
        load_basic();
        pulse_start();
        capture(30);
        checks++;
        if (done_cyc !== 9) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 9", done_cyc); end
        checks++;
        if (first_rd !== 1 || n_rd !== 3) begin
            errors++; $display("FAIL basic_reads: first %0d count %0d expected 1 and 3", first_rd, n_rd);
        end
        checks++;
        if (first_wr !== 5 || n_wr !== 4) begin
            errors++; $display("FAIL basic_writes: first %0d count %0d expected 5 and 4", first_wr, n_wr);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wr_addr[k] !== 4 + k || wr_score[k] !== exp_s[k] || wr_id[k] !== exp_i[k] || wr_match[k] !== exp_m[k]) begin
                errors++;
                $display("FAIL basic_lane%0d: addr %0d score %0d id %0d match %0d expected %0d %0d %0d %0d",
                         k, wr_addr[k], wr_score[k], wr_id[k], wr_match[k], 4 + k, exp_s[k], exp_i[k], exp_m[k]);
            end
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_in_done: got %0b expected 1", busy); end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done_score_calc !== 1'b0) begin
            errors++; $display("FAIL basic_idle_after: busy %0b done %0b expected 0 0", busy, done_score_calc);
        end
    endtask

    task automatic test_tie();
        for (int i = 0; i < 4; i++) set_lane(i, 5, 5);
        set_prev(0, 4, 5);
        set_prev(1, 6, 5);
        num_of_prev = 6'd2; score_th = 12'd0; set_index = 4'd0;
        pulse_start();
        capture(30);
        checks++;
        if (wr_score[0] !== 1 || wr_id[0] !== 0 || wr_match[0] !== 0) begin
            errors++; $display("FAIL tie_two: score %0d id %0d match %0d expected 1 0 0", wr_score[0], wr_id[0], wr_match[0]);
        end
        @(posedge clk); #1;
        set_prev(0, 5, 4);
        set_prev(1, 5, 6);
        set_prev(2, 4, 5);
        num_of_prev = 6'd3; score_th = 12'd1;
        pulse_start();
        capture(30);
        checks++;
        if (wr_score[3] !== 1 || wr_id[3] !== 0 || wr_match[3] !== 1) begin
            errors++; $display("FAIL tie_three: score %0d id %0d match %0d expected 1 0 1", wr_score[3], wr_id[3], wr_match[3]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_prev();
        num_of_prev = 6'd0; score_th = 12'hFFF; set_index = 4'd5;
        pulse_start();
        capture(30);
        checks++;
        if (done_cyc !== 5 || first_wr !== 1 || n_rd !== 0 || n_wr !== 4) begin
            errors++; $display("FAIL zero_timing: done %0d first_wr %0d reads %0d writes %0d expected 5 1 0 4",
                               done_cyc, first_wr, n_rd, n_wr);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wr_score[k] !== 12'hFFF || wr_id[k] !== 0 || wr_match[k] !== 0 || wr_addr[k] !== 20 + k) begin
                errors++; $display("FAIL zero_lane%0d: score %0h id %0d match %0d addr %0d expected fff 0 0 %0d",
                                   k, wr_score[k], wr_id[k], wr_match[k], wr_addr[k], 20 + k);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) set_lane(i, 5, 5);
        set_prev(0, 4, 5);
        set_prev(1, 6, 5);
        num_of_prev = 6'd1; score_th = 12'd3; set_index = 4'd2;
        pulse_start();
        capture(30);
        checks++;
        if (done_cyc !== 7 || wr_addr[0] !== 8) begin
            errors++; $display("FAIL b2b_first: done %0d addr0 %0d expected 7 8", done_cyc, wr_addr[0]);
        end
        set_index = 4'd3; num_of_prev = 6'd2;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || prev_rd_en !== 1'b1) begin
            errors++; $display("FAIL b2b_no_idle: busy %0b rd_en %0b expected 1 1", busy, prev_rd_en);
        end
        capture(30);
        checks++;
        if (first_rd !== 1 || done_cyc !== 8) begin
            errors++; $display("FAIL b2b_second_timing: first_rd %0d done %0d expected 1 8", first_rd, done_cyc);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wr_addr[k] !== 12 + k || wr_score[k] !== 1 || wr_id[k] !== 0) begin
                errors++; $display("FAIL b2b_lane%0d: addr %0d score %0d id %0d expected %0d 1 0",
                                   k, wr_addr[k], wr_score[k], wr_id[k], 12 + k);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_extremes();
        int bad;
        set_lane(0, 0, 0);
        set_lane(1, 2047, 2047);
        set_prev(0, 2047, 2047);
        num_of_prev = 6'd1; score_th = 12'd4094; set_index = 4'd0;
        pulse_start();
        capture(30);
        checks++;
        if (wr_score[0] !== 4094 || wr_match[0] !== 1 || wr_score[1] !== 0) begin
            errors++; $display("FAIL extreme_score: lane0 %0d match %0d lane1 %0d expected 4094 1 0",
                               wr_score[0], wr_match[0], wr_score[1]);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 32; k++) set_prev(k, k, k);
        set_lane(0, 100, 100);
        set_lane(1, 0, 0);
        num_of_prev = 6'd40; score_th = 12'd0;
        pulse_start();
        capture(80);
        bad = 0;
        for (int k = 0; k < n_rd; k++) if (rd_addr[k] !== k) bad++;
        checks++;
        if (n_rd !== 32 || bad !== 0 || done_cyc !== 38) begin
            errors++; $display("FAIL clamp_reads: count %0d bad_addr %0d done %0d expected 32 0 38", n_rd, bad, done_cyc);
        end
        checks++;
        if (wr_score[0] !== 138 || wr_id[0] !== 31 || wr_score[1] !== 0 || wr_id[1] !== 0) begin
            errors++; $display("FAIL clamp_best: lane0 %0d/%0d lane1 %0d/%0d expected 138/31 0/0",
                               wr_score[0], wr_id[0], wr_score[1], wr_id[1]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_read();
        logic [40:0] outs;
        int seen;
        load_basic();
        pulse_start();
        @(posedge clk); #1;
        checks++;
        if (prev_rd_en !== 1'b1 || prev_rd_addr !== 5'd1) begin
            errors++; $display("FAIL midreset_pre: rd_en %0b addr %0d expected 1 1", prev_rd_en, prev_rd_addr);
        end
        #2 reset_N = 1'b0;
        #1;
        outs = {prev_rd_en, prev_rd_addr, sb_wr_en, sb_wr_addr, sb_best_score,
                sb_best_id, sb_match, done_score_calc, busy};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL midreset_outputs: got %h expected 0", outs); end
        repeat (2) @(posedge clk);
        @(negedge clk); reset_N = 1'b1;
        @(posedge clk); #1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (done_score_calc || sb_wr_en || busy) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midreset_quiet: active cycles %0d expected 0", seen); end
        pulse_start();
        capture(30);
        checks++;
        if (done_cyc !== 9 || wr_score[0] !== 3 || wr_id[0] !== 1 || wr_match[0] !== 1) begin
            errors++; $display("FAIL midreset_rerun: done %0d score %0d id %0d match %0d expected 9 3 1 1",
                               done_cyc, wr_score[0], wr_id[0], wr_match[0]);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset_N = 1'b0;
        start_score_calc = 1'b0;
        set_index = '0;
        num_of_prev = '0;
        cur_set = '0;
        score_th = '0;
        prev_rd_data = '0;
        for (int k = 0; k < 32; k++) prev_mem[k] = '0;
        repeat (2) @(posedge clk); #1;
        test_reset();
        reset_N = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_tie();
        test_zero_prev();
        test_back_to_back();
        test_extremes();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
